// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared encodings and control bundle for the pipeline hold/flush sequencer.
// FSM codes, bank indices and redirect select values live here.
package pipe_hold_ctrl_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_REDIR = 2'd3;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  localparam logic REDIR_BR   = 1'b0;
  localparam logic REDIR_TRAP = 1'b1;

  typedef struct packed {
    logic       pc_lden;
    logic       redir;
    logic       sel;
    logic       ack;
    logic [3:0] lden;
    logic [3:0] flush;
  } ctl_t;

  function automatic ctl_t mk_ctl(
    input logic       pc_lden,
    input logic       redir,
    input logic       sel,
    input logic       ack,
    input logic [3:0] lden,
    input logic [3:0] flush
  );
    ctl_t c;
    c.pc_lden = pc_lden;
    c.redir   = redir;
    c.sel     = sel;
    c.ack     = ack;
    c.lden    = lden;
    c.flush   = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_stall_mon.sv
// Consecutive-stall counter with saturation and registered hang flag.
// Counter clears on any PC advance or while the sequencer is booting.
module pipe_stall_mon
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int CW         = 8,
  parameter int HANG_LIMIT = 200
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_stall,
  output logic [CW-1:0] o_cnt,
  output logic          o_hang
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LIMIT   = CW'(HANG_LIMIT);

  logic [CW-1:0] r_cnt;
  logic          r_hang;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (i_stall && (r_cnt != CNT_MAX))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_hang <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_hang <= (w_cnt_nxt >= LIMIT);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_hang = r_hang;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central stall/flush sequencer: PC and pipeline-bank load/bubble controls
// for load-use, multi-cycle EX, memory wait, branch redirect and trap entry.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int CW         = 8,
  parameter int HANG_LIMIT = 200
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ld_use_hzd_i,
  input  logic          ex_busy_i,
  input  logic          mem_wait_i,
  input  logic          br_flush_i,
  input  logic          trap_req_i,
  output logic          pc_lden_o,
  output logic          redir_o,
  output logic          redir_sel_o,
  output logic [3:0]    stg_lden_o,
  output logic [3:0]    stg_flush_o,
  output logic          trap_ack_o,
  output logic [CW-1:0] stall_cnt_o,
  output logic          hang_o
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  ctl_t       w_ctl;

  logic w_sel_mw;
  logic w_sel_eb;
  logic w_sel_br;
  logic w_sel_lu;
  logic w_sel_none;
  logic w_mon_clr;
  logic w_mon_stall;

  // RUN priority flattened into one-hot selects
  assign w_sel_mw   = mem_wait_i;
  assign w_sel_eb   = ex_busy_i & ~mem_wait_i;
  assign w_sel_br   = br_flush_i & ~ex_busy_i
                    & ~mem_wait_i;
  assign w_sel_lu   = ld_use_hzd_i & ~br_flush_i
                    & ~ex_busy_i & ~mem_wait_i;
  assign w_sel_none = ~(mem_wait_i | ex_busy_i
                    | br_flush_i | ld_use_hzd_i);

  always_comb begin
    w_ctl = mk_ctl(1'b0, 1'b0, REDIR_BR, 1'b0,
                   4'b1111, 4'b1111);
    unique case (r_state)
      ST_BOOT: begin
        w_ctl = mk_ctl(1'b0, 1'b0, REDIR_BR, 1'b0,
                       4'b1111, 4'b1111);
      end
      ST_RUN: begin
        unique case (1'b1)
          w_sel_mw:
            w_ctl = mk_ctl(1'b0, 1'b0, REDIR_BR, 1'b0,
                           4'b1000, 4'b1000);
          w_sel_eb:
            w_ctl = mk_ctl(1'b0, 1'b0, REDIR_BR, 1'b0,
                           4'b1100, 4'b0100);
          w_sel_br:
            w_ctl = mk_ctl(1'b1, 1'b1, REDIR_BR, 1'b0,
                           4'b1111, 4'b0011);
          w_sel_lu:
            w_ctl = mk_ctl(1'b0, 1'b0, REDIR_BR, 1'b0,
                           4'b1110, 4'b0010);
          w_sel_none:
            w_ctl = mk_ctl(1'b1, 1'b0, REDIR_BR, 1'b0,
                           4'b1111, 4'b0000);
          default: ;
        endcase
      end
      ST_DRAIN: begin
        w_ctl = mk_ctl(1'b0, 1'b0, REDIR_BR, 1'b0,
                       4'b1111, 4'b0111);
        w_ctl.flush[MEMWB] = mem_wait_i;
      end
      ST_REDIR: begin
        w_ctl = mk_ctl(1'b1, 1'b1, REDIR_TRAP, 1'b1,
                       4'b1111, 4'b0001);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = trap_req_i ? ST_DRAIN
                                         : ST_RUN;
      ST_DRAIN: w_state_nxt = mem_wait_i ? ST_DRAIN
                                         : ST_REDIR;
      ST_REDIR: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= ST_BOOT;
    else
      r_state <= w_state_nxt;
  end

  assign w_mon_clr   = (r_state == ST_BOOT)
                     | w_ctl.pc_lden;
  assign w_mon_stall = ~w_ctl.pc_lden;

  pipe_stall_mon #(
    .CW         (CW),
    .HANG_LIMIT (HANG_LIMIT)
  ) u_mon (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_mon_clr),
    .i_stall (w_mon_stall),
    .o_cnt   (stall_cnt_o),
    .o_hang  (hang_o)
  );

  assign pc_lden_o   = w_ctl.pc_lden;
  assign redir_o     = w_ctl.redir;
  assign redir_sel_o = w_ctl.sel;
  assign trap_ack_o  = w_ctl.ack;
  assign stg_lden_o  = w_ctl.lden;
  assign stg_flush_o = w_ctl.flush;

endmodule
